// File: rtl/maze_tile_renderer.sv
// maze_tile_renderer: 3-stage tile-map pixel renderer with RMW map writer; `define POWER_PELLET_BLINK_EN blinks power pellets
module maze_tile_renderer #(
  parameter int PIXELS_WIDTH     = 16,
  parameter int REL_BITS         = 4,
  parameter int PIXEL_COLOR_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [9:0]                  hcount,
  input  logic [9:0]                  vcount,
  input  logic                        video_on,
  input  logic                        pix_en,
  input  logic                        map_we,
  input  logic [9:0]                  map_addr,
  input  logic [1:0]                  map_wdata,
  output logic                        map_ready,
  output logic [REL_BITS-1:0]         wall_x,
  output logic [REL_BITS-1:0]         wall_y,
  input  logic [PIXEL_COLOR_BITS-1:0] wall_pixels,
  output logic [PIXEL_COLOR_BITS-1:0] pixel_color,
  output logic                        pixel_en_out,
  output logic [10:0]                 pellets_left,
  output logic                        maze_clear
);
  localparam int SH = $clog2(PIXELS_WIDTH);
  typedef enum logic [1:0] {CLEAR, IDLE, RMW_RD, RMW_WR} state_t;
  state_t state_q;
  logic [1:0] mem [1024];
  logic [9:0] sweep_q, addr_q, col, row, mem_wa;
  logic [1:0] data_q, old_q, mem_wd;
  logic ready_q, mem_we;
  logic [10:0] pellets_q;
  logic [9:0] addr1_q;
  logic oob1_q, von1_q, pen1_q;
  logic [REL_BITS-1:0] rx1_q, ry1_q, rx2_q, ry2_q;
  logic [1:0] code2_q;
  logic oob2_q, von2_q, pen2_q;
  logic [PIXEL_COLOR_BITS-1:0] wpix2_q, color_d, color_q;
  logic pen3_q, in_small, in_big, blank;
  assign col = hcount >> SH;
  assign row = vcount >> SH;
  assign wall_x = rx1_q;
  assign wall_y = ry1_q;
  assign map_ready = ready_q;
  assign pellets_left = pellets_q;
  assign maze_clear = pellets_q == 11'd0 && state_q == IDLE;
  assign pixel_color = color_q;
  assign pixel_en_out = pen3_q;
  assign mem_we = state_q == CLEAR || state_q == RMW_WR;
  assign mem_wa = state_q == CLEAR ? sweep_q : addr_q;
  assign mem_wd = state_q == CLEAR ? 2'b00 : data_q;
`ifdef POWER_PELLET_BLINK_EN
  logic [4:0] frame_q;
  // frame counter advances on the first pixel of each frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_q <= '0;
    else if (pix_en && hcount == 10'd0 && vcount == 10'd0) frame_q <= frame_q + 5'd1;
  assign blank = frame_q[4];
`else
  assign blank = 1'b0;
`endif
  // map write port; nonblocking update means same-clock display reads see old data
  always_ff @(posedge clk)
    if (mem_we) mem[mem_wa] <= mem_wd;
  // write FSM: clear sweep, then accept one read-modify-write at a time
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= CLEAR;
      sweep_q   <= '0;
      ready_q   <= 1'b0;
      pellets_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      old_q     <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          sweep_q <= sweep_q + 10'd1;
          if (sweep_q == 10'd1023) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        IDLE: if (map_we) begin
          addr_q  <= map_addr;
          data_q  <= map_wdata;
          ready_q <= 1'b0;
          state_q <= RMW_RD;
        end
        RMW_RD: begin
          old_q   <= mem[addr_q];
          state_q <= RMW_WR;
        end
        RMW_WR: begin
          pellets_q <= pellets_q + 11'(data_q[1]) - 11'(old_q[1]);
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  // stage 1: split screen coordinates into tile address and in-tile offset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr1_q <= '0;
      oob1_q  <= 1'b0;
      rx1_q   <= '0;
      ry1_q   <= '0;
      von1_q  <= 1'b0;
      pen1_q  <= 1'b0;
    end else begin
      addr1_q <= {row[4:0], col[4:0]};
      oob1_q  <= |col[9:5] || |row[9:5];
      rx1_q   <= hcount[REL_BITS-1:0];
      ry1_q   <= vcount[REL_BITS-1:0];
      von1_q  <= video_on;
      pen1_q  <= pix_en;
    end
  // stage 2: synchronous map read, wall graphic captured alongside
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      code2_q <= '0;
      oob2_q  <= 1'b0;
      rx2_q   <= '0;
      ry2_q   <= '0;
      von2_q  <= 1'b0;
      pen2_q  <= 1'b0;
      wpix2_q <= '0;
    end else begin
      code2_q <= mem[addr1_q];
      oob2_q  <= oob1_q;
      rx2_q   <= rx1_q;
      ry2_q   <= ry1_q;
      von2_q  <= von1_q;
      pen2_q  <= pen1_q;
      wpix2_q <= wall_pixels;
    end
  // colour select from tile code and in-tile position
  always_comb begin
    in_small = (rx2_q == 7 || rx2_q == 8) && (ry2_q == 7 || ry2_q == 8);
    in_big   = rx2_q >= 4 && rx2_q <= 11 && ry2_q >= 4 && ry2_q <= 11;
    color_d  = (!von2_q || oob2_q) ? '0 :
               code2_q == 2'd1 ? wpix2_q :
               code2_q == 2'd2 ? (in_small ? '1 : '0) :
               code2_q == 2'd3 ? (in_big && !blank ? '1 : '0) : '0;
  end
  // stage 3: registered pixel output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      color_q <= '0;
      pen3_q  <= 1'b0;
    end else begin
      color_q <= color_d;
      pen3_q  <= pen2_q;
    end
endmodule

// File: tb/tb_maze_tile_renderer.sv
// tb_maze_tile_renderer: directed scoreboard bench for maze_tile_renderer
module tb_maze_tile_renderer;
  logic clk = 0, rst_n = 0;
  logic [9:0] hcount = 0, vcount = 0, map_addr = 0;
  logic video_on = 0, pix_en = 0, map_we = 0;
  logic [1:0] map_wdata = 0;
  logic map_ready, pixel_en_out, maze_clear;
  logic [3:0] wall_x, wall_y;
  logic [7:0] wall_pixels = 8'hC0, pixel_color;
  logic [10:0] pellets_left;
  typedef struct {logic [7:0] c; int t;} exp_t;
  exp_t q[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  maze_tile_renderer dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .video_on(video_on),
    .pix_en(pix_en), .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
    .map_ready(map_ready), .wall_x(wall_x), .wall_y(wall_y), .wall_pixels(wall_pixels),
    .pixel_color(pixel_color), .pixel_en_out(pixel_en_out), .pellets_left(pellets_left),
    .maze_clear(maze_clear)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (pixel_en_out === 1'b1) begin
      if (q.size() == 0) chk("unexpected pixel_en_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("pixel_color", int'(pixel_color), int'(e.c));
        chk("pixel latency", cyc - e.t, 3);
      end
    end
  end
  task automatic pix(input int h, input int v, input logic von, input logic [7:0] ec);
    exp_t e;
    @(negedge clk);
    hcount = h[9:0]; vcount = v[9:0]; video_on = von; pix_en = 1;
    e.c = ec; e.t = cyc; q.push_back(e);
    @(posedge clk); #1;
    chk("wall_x", int'(wall_x), h % 16);
    chk("wall_y", int'(wall_y), v % 16);
    pix_en = 0;
  endtask
  task automatic wr(input int a, input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (!map_ready && n < 2000) begin @(negedge clk); n++; end
    if (!map_ready) chk("map_ready timeout", 0, 1);
    map_we = 1; map_addr = a[9:0]; map_wdata = d[1:0];
    @(negedge clk);
    map_we = 0; n = 0;
    while (!map_ready && n < 10) begin n++; @(negedge clk); end
    chk("write busy clocks", n, 2);
  endtask
  task automatic clear_len();
    int n;
    n = 0;
    do begin @(posedge clk); n++; #1; end while (!map_ready && n < 3000);
    chk("clear clocks", n, 1024);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("scoreboard drained", q.size(), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset map_ready", map_ready, 0);
    chk("reset pellets", pellets_left, 0);
    chk("reset maze_clear", maze_clear, 0);
    chk("reset pixel_color", pixel_color, 0);
    chk("reset pixel_en_out", pixel_en_out, 0);
    @(negedge clk) rst_n = 1;
    clear_len();
    chk("pellets after clear", pellets_left, 0);
    chk("maze_clear after clear", maze_clear, 1);
    pix(23, 23, 1, 8'h00);
    wr(33, 2);
    chk("pellets after pellet", pellets_left, 1);
    chk("maze_clear with pellet", maze_clear, 0);
    pix(23, 23, 1, 8'hFF);
    pix(16, 16, 1, 8'h00);
    pix(24, 23, 1, 8'hFF);
    pix(25, 23, 1, 8'h00);
    pix(23, 23, 0, 8'h00);
    wr(0, 1);
    pix(5, 9, 1, 8'hC0);
    pix(5, 9, 0, 8'h00);
    pix(15, 15, 1, 8'hC0);
    wr(33, 3);
    chk("pellets pellet->power", pellets_left, 1);
    pix(20, 20, 1, 8'hFF);
    pix(19, 20, 1, 8'h00);
    pix(27, 27, 1, 8'hFF);
    pix(28, 27, 1, 8'h00);
`ifdef POWER_PELLET_BLINK_EN
    repeat (16) pix(0, 0, 1, 8'hC0);
    pix(20, 20, 1, 8'h00);
    repeat (16) pix(0, 0, 1, 8'hC0);
    pix(20, 20, 1, 8'hFF);
`endif
    wr(37, 1);
    chk("pellets after wall", pellets_left, 1);
    wr(33, 0);
    chk("pellets after erase", pellets_left, 0);
    chk("maze_clear after erase", maze_clear, 1);
    pix(600, 23, 1, 8'h00);
    pix(85, 23, 1, 8'hC0);
    pix(5, 521, 1, 8'h00);
    wr(1023, 2);
    chk("pellets corner", pellets_left, 1);
    pix(503, 503, 1, 8'hFF);
    drain();
    @(negedge clk);
    map_we = 1; map_addr = 10'd256; map_wdata = 2'd2;
    @(negedge clk);
    map_we = 0;
    rst_n = 0;
    #1;
    chk("abort map_ready", map_ready, 0);
    chk("abort pellets", pellets_left, 0);
    chk("abort maze_clear", maze_clear, 0);
    chk("abort pixel_color", pixel_color, 0);
    chk("abort pixel_en_out", pixel_en_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    clear_len();
    chk("pellets after re-clear", pellets_left, 0);
    pix(7, 135, 1, 8'h00);
    pix(503, 503, 1, 8'h00);
    pix(5, 9, 1, 8'h00);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/maze_tile_renderer.md
MAZE_TILE_RENDERER -- requirements
Module: maze_tile_renderer

Interface
REQ-001 SHALL have parameters: PIXELS_WIDTH, default 16, tile edge in pixels; REL_BITS, default 4, tile-relative coordinate width; PIXEL_COLOR_BITS, default 8, RGB332 colour width.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock
- rst_n  in  1  async active-low reset
- hcount  in  10  screen x
- vcount  in  10  screen y
- video_on  in  1  visible region
- pix_en  in  1  pixel strobe
- map_we  in  1  write request
- map_addr  in  10  {row[4:0], col[4:0]}
- map_wdata  in  2  tile code: 0 empty, 1 wall, 2 pellet, 3 power pellet
- map_ready  out  1  write accepted when high with map_we
- wall_x  out  REL_BITS  to wall graphic
- wall_y  out  REL_BITS  to wall graphic
- wall_pixels  in  PIXEL_COLOR_BITS  from wall graphic, combinational
- pixel_color  out  PIXEL_COLOR_BITS  final colour
- pixel_en_out  out  1  pix_en delayed to match pixel_color
- pellets_left  out  11  count of tiles coded 2 or 3
- maze_clear  out  1  pellets_left==0 and FSM in IDLE

Function
REQ-003 SHALL hold a 1024x2 map RAM; the display read port is synchronous and the write port is separate (dual port).
REQ-004 Stage 1 SHALL register col=hcount/16, row=vcount/16, rel_x=hcount[3:0], rel_y=vcount[3:0], video_on and pix_en every clock (free-running, no stall).
REQ-005 Stage 2 SHALL read the map at {row,col} and SHALL drive wall_x/wall_y from the stage-1 registered rel_x/rel_y.
REQ-006 Stage 3 SHALL register pixel_color and pixel_en_out; total latency is exactly 3 clk from input to output.
REQ-007 Colour select: video_on low -> 0; col>=32 or row>=32 -> 0; code 1 -> wall_pixels; code 2 -> 8'hFF when rel_x and rel_y are both in 7..8, else 0; code 3 -> 8'hFF when both are in 4..11, else 0; code 0 -> 0.
REQ-008 Write FSM states: CLEAR, IDLE, RMW_RD, RMW_WR.
REQ-009 CLEAR SHALL write code 0 to addresses 0..1023, one per clk, with map_ready=0, then go to IDLE.
REQ-010 IDLE SHALL drive map_ready=1; map_we=1 SHALL latch addr/data and go to RMW_RD.
REQ-011 RMW_RD SHALL read the old code, with map_ready=0.
REQ-012 RMW_WR SHALL write the new code and SHALL update pellets_left += (new is 2/3) - (old is 2/3), then return to IDLE; one write occupies 3 clk.
REQ-013 A display read to the address being written in the same clk SHALL return the old data.
REQ-014 pellets_left SHALL never wrap; this is guaranteed by REQ-012 arithmetic, with maximum 1024.

Reset
REQ-015 rst_n low SHALL asynchronously force: FSM=CLEAR with sweep address 0, map_ready=0, pellets_left=0, maze_clear=0, pixel_color=0, pixel_en_out=0, and all pipeline registers 0.
REQ-016 Reset asserted mid-RMW SHALL abandon the write and restart CLEAR on release.
REQ-017 During CLEAR the display path SHALL keep running and output whatever the map holds.

Configuration
REQ-018 With POWER_PELLET_BLINK_EN defined, a 5-bit frame counter SHALL increment on pix_en with hcount==0 and vcount==0 (reset 0), and code-3 tiles SHALL render as 0 while counter bit 4 is 1.
REQ-019 Without POWER_PELLET_BLINK_EN, no frame counter SHALL exist and code-3 tiles SHALL always render.

Verification
REQ-020 Release reset -> map_ready low for exactly 1024 clk, then high; pellets_left=0; maze_clear=1.
REQ-021 Write code 2 to addr 0x021 -> map_ready low 2 clk; pellets_left=1; hcount=23,vcount=23 yields pixel_color=8'hFF 3 clk later; hcount=16,vcount=16 yields 0.
REQ-022 Write code 1 to addr 0x000, with wall_pixels tied to 8'b11000000 -> hcount=5,vcount=9 gives wall_x=5, wall_y=9, and pixel_color=8'b11000000 after 3 clk.
REQ-023 Overwrite a pellet tile with code 3 -> pellets_left unchanged; then write code 0 -> pellets_left decrements; hcount=600 (col 37) -> pixel_color 0.
REQ-024 Assert rst_n during RMW_RD -> outputs zero immediately; CLEAR restarts; the abandoned write is not applied.
REQ-025 With POWER_PELLET_BLINK_EN, a code-3 tile visible in frames 0..15 -> black in frames 16..31, then visible again in frame 32.
